// File: rtl/node_msg_rx_writer.sv
// Inbound flit-stream receiver: packs each message into a ring of fixed-size slots in
// processing memory port 2, writing a {trunc, len} header word once the message ends.
module node_msg_rx_writer #(
    parameter logic [13:0] BASE_ADDR  = 14'h2600,
    parameter int          NUM_SLOTS  = 4,
    parameter int          SLOT_WORDS = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_sop,
    input  logic                           in_eop,
    input  logic [15:0]                    in_data,
    output logic                           in_ready,
    output logic [13:0]                    address2,
    output logic [15:0]                    writedata2,
    output logic [1:0]                     byteenable2,
    output logic                           chipselect2,
    output logic                           write2,
    output logic                           clken2,
    input  logic                           rel,
    output logic [$clog2(NUM_SLOTS)-1:0]   rd_slot,
    output logic [$clog2(NUM_SLOTS):0]     pending,
    output logic                           irq,
    output logic [7:0]                     drop_count
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int PW = SW + 1;

    typedef enum logic [1:0] {IDLE, RECV, HDR, DROP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   wr_slot_q, wr_slot_d;
    logic [SW-1:0]   rd_slot_q, rd_slot_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic [7:0]      drop_q, drop_d;
    logic            trunc_q, trunc_d;
    logic [14:0]     len_q, len_d;
    logic            write2_q, write2_d;
    logic [13:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            irq_q, irq_d;

    logic            accept_s;
    logic            commit_s;
    logic            rel_ok_s;
    logic [13:0]     slot_base_s;

    assign in_ready    = (state_q != HDR);
    assign accept_s    = in_valid && in_ready;
    assign commit_s    = (state_q == HDR);
    assign rel_ok_s    = rel && (pending_q != PW'(0));
    assign slot_base_s = BASE_ADDR + 14'(wr_slot_q) * 14'(SLOT_WORDS);

    assign address2    = addr_q;
    assign writedata2  = wdata_q;
    assign write2      = write2_q;
    assign chipselect2 = write2_q;
    assign byteenable2 = 2'b11;
    assign clken2      = 1'b1;
    assign rd_slot     = rd_slot_q;
    assign pending     = pending_q;
    assign irq         = irq_q;
    assign drop_count  = drop_q;

    // Next-state, payload/header write generation and slot bookkeeping
    always_comb begin
        state_d   = state_q;
        wr_slot_d = wr_slot_q;
        rd_slot_d = rd_slot_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        trunc_d   = trunc_q;
        len_d     = len_q;
        write2_d  = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                if (accept_s && in_sop) begin
                    // Availability uses pending as registered at this sop edge
                    if (pending_q == PW'(NUM_SLOTS)) begin
                        drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                        state_d = in_eop ? IDLE : DROP;
                    end else begin
                        write2_d = 1'b1;
                        addr_d   = slot_base_s + 14'd1;
                        wdata_d  = in_data;
                        len_d    = 15'd1;
                        trunc_d  = 1'b0;
                        state_d  = in_eop ? HDR : RECV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (accept_s) begin
                    // len_q beats already stored, so this beat lands at offset len_q+1
                    if (len_q < 15'(SLOT_WORDS - 1)) begin
                        write2_d = 1'b1;
                        addr_d   = slot_base_s + 14'(len_q) + 14'd1;
                        wdata_d  = in_data;
                    end else begin
                        trunc_d = 1'b1;
                    end
                    len_d   = (len_q == 15'h7FFF) ? len_q : len_q + 15'd1;
                    state_d = in_eop ? HDR : RECV;
                end else begin
                    state_d = RECV;
                end
            end
            HDR: begin
                write2_d  = 1'b1;
                addr_d    = slot_base_s;
                wdata_d   = {trunc_q, len_q};
                wr_slot_d = wr_slot_q + SW'(1);
                state_d   = IDLE;
            end
            DROP: begin
                if (accept_s && in_eop) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rel_ok_s) begin
            rd_slot_d = rd_slot_q + SW'(1);
        end else begin
            rd_slot_d = rd_slot_q;
        end

        case ({commit_s, rel_ok_s})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase

        irq_d = (pending_d != PW'(0));
    end

    // State and registered memory-port outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            pending_q <= '0;
            drop_q    <= 8'd0;
            trunc_q   <= 1'b0;
            len_q     <= 15'd0;
            write2_q  <= 1'b0;
            addr_q    <= 14'd0;
            wdata_q   <= 16'd0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            trunc_q   <= trunc_d;
            len_q     <= len_d;
            write2_q  <= write2_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            irq_q     <= irq_d;
        end
    end
endmodule

// File: tb/tb_node_msg_rx_writer.sv
// Scoreboard bench for node_msg_rx_writer with default parameters: expected port-2
// writes are queued as stimulus is driven and matched against each registered write.
module tb_node_msg_rx_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_sop, in_eop;
    logic [15:0] in_data;
    logic        in_ready;
    logic [13:0] address2;
    logic [15:0] writedata2;
    logic [1:0]  byteenable2;
    logic        chipselect2, write2, clken2;
    logic        rel;
    logic [1:0]  rd_slot;
    logic [2:0]  pending;
    logic        irq;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;
    logic [29:0] exp_q[$];
    int m_wr, m_rd, m_pend, m_drop;
    logic last_hdr_ready;

    node_msg_rx_writer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .in_ready(in_ready),
        .address2(address2), .writedata2(writedata2), .byteenable2(byteenable2),
        .chipselect2(chipselect2), .write2(write2), .clken2(clken2),
        .rel(rel), .rd_slot(rd_slot), .pending(pending), .irq(irq),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_addr(input int slot, input int off);
        int a;
        a = 'h2600 + slot * 32 + off;
        return a[13:0];
    endfunction

    // One clock; then match any port-2 write against the scoreboard head
    task automatic tick();
        logic [29:0] e;
        @(posedge clk);
        #1;
        checks++;
        if (write2 === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", address2, writedata2);
            end else begin
                e = exp_q.pop_front();
                if ({address2, writedata2} !== e || chipselect2 !== 1'b1 || byteenable2 !== 2'b11 || clken2 !== 1'b1) begin
                    errors++;
                    $display("FAIL port2_write: got addr=%h data=%h cs=%b be=%b, required addr=%h data=%h cs=1 be=11",
                             address2, writedata2, chipselect2, byteenable2, e[29:16], e[15:0]);
                end
            end
        end else if (chipselect2 !== 1'b0 || write2 !== 1'b0) begin
            errors++;
            $display("FAIL port2_idle: got cs=%b we=%b, required 0 0", chipselect2, write2);
        end
    endtask

    task automatic send_msg(input int n, input logic [15:0] base, input bit rel_at_hdr);
        bit drop;
        int guard;
        logic [15:0] hdr;
        drop = (m_pend == 4);
        if (!drop) begin
            for (int i = 1; i <= n; i++) begin
                if (i <= 31) exp_q.push_back({exp_addr(m_wr, i), base + 16'(i - 1)});
            end
            hdr = {(n > 31) ? 1'b1 : 1'b0, 15'(n)};
            exp_q.push_back({exp_addr(m_wr, 0), hdr});
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_eop   = (i == n - 1);
            in_data  = base + 16'(i);
            guard = 0;
            while (in_ready !== 1'b1 && guard < 8) begin
                tick();
                guard++;
            end
            if (guard >= 8) begin
                errors++;
                $display("FAIL ready_timeout: in_ready=%b, required 1 within 8 cycles", in_ready);
            end
            tick();
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        last_hdr_ready = in_ready;
        rel = rel_at_hdr;
        tick();
        rel = 1'b0;
        if (drop) begin
            m_drop = (m_drop == 255) ? 255 : m_drop + 1;
            if (rel_at_hdr && m_pend != 0) begin
                m_pend--;
                m_rd = (m_rd + 1) % 4;
            end
        end else begin
            m_wr = (m_wr + 1) % 4;
            if (rel_at_hdr && m_pend != 0) m_rd = (m_rd + 1) % 4;
            else m_pend++;
        end
    endtask

    task automatic do_rel();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        if (m_pend != 0) begin
            m_pend--;
            m_rd = (m_rd + 1) % 4;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 16'h0000; rel = 1'b0;
        exp_q.delete();
        m_wr = 0; m_rd = 0; m_pend = 0; m_drop = 0;
        tick(); tick();
        checks++;
        if (address2 !== 14'd0 || writedata2 !== 16'd0 || write2 !== 1'b0 || pending !== 3'd0 ||
            rd_slot !== 2'd0 || irq !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got addr=%h data=%h we=%b pend=%0d rd=%0d irq=%b drops=%0d, required all 0",
                     address2, writedata2, write2, pending, rd_slot, irq, drop_count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_rel_empty();
        do_rel();
        checks++;
        if (pending !== 3'd0 || rd_slot !== 2'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rel_empty: got pend=%0d rd=%0d irq=%b, required 0 0 0", pending, rd_slot, irq);
        end
    endtask

    task automatic test_basic();
        send_msg(3, 16'h00A1, 1'b0);
        checks++;
        if (pending !== 3'd1 || irq !== 1'b1 || rd_slot !== 2'd0) begin
            errors++;
            $display("FAIL basic_status: got pend=%0d irq=%b rd=%0d, required 1 1 0", pending, irq, rd_slot);
        end
    endtask

    task automatic test_single();
        send_msg(1, 16'h55AA, 1'b0);
        checks++;
        if (last_hdr_ready !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got hdr=%b after=%b, required 0 1", last_hdr_ready, in_ready);
        end
    endtask

    task automatic test_trunc();
        send_msg(40, 16'h1000, 1'b0);
        checks++;
        if (pending !== 3'(m_pend)) begin
            errors++;
            $display("FAIL trunc_pending: got %0d, required %0d", pending, m_pend);
        end
    endtask

    task automatic test_full_drop();
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = 16'hDEAD;
        tick();
        in_valid = 1'b0; in_eop = 1'b0;
        send_msg(2, 16'h2000, 1'b0);
        send_msg(2, 16'h3000, 1'b0);
        send_msg(5, 16'h4000, 1'b0);
        checks++;
        if (pending !== 3'd4 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL full_drop: got pend=%0d drops=%0d, required 4 1", pending, drop_count);
        end
        send_msg(1, 16'h5000, 1'b0);
        checks++;
        if (drop_count !== 8'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_single: got drops=%0d ready=%b, required 2 1", drop_count, in_ready);
        end
        do_rel();
        checks++;
        if (pending !== 3'd3 || rd_slot !== 2'd1) begin
            errors++;
            $display("FAIL rel_one: got pend=%0d rd=%0d, required 3 1", pending, rd_slot);
        end
        send_msg(2, 16'h6000, 1'b0);
        checks++;
        if (pending !== 3'd4 || m_wr != 1) begin
            errors++;
            $display("FAIL refill: got pend=%0d, required 4", pending);
        end
    endtask

    task automatic test_rel_at_hdr();
        do_rel();
        do_rel();
        checks++;
        if (pending !== 3'd2 || rd_slot !== 2'd3) begin
            errors++;
            $display("FAIL rel_two: got pend=%0d rd=%0d, required 2 3", pending, rd_slot);
        end
        send_msg(2, 16'h7000, 1'b1);
        checks++;
        if (pending !== 3'd2 || rd_slot !== 2'd0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL rel_at_hdr: got pend=%0d rd=%0d irq=%b, required 2 0 1", pending, rd_slot, irq);
        end
        send_msg(1, 16'h7100, 1'b0);
        checks++;
        if (pending !== 3'd3) begin
            errors++;
            $display("FAIL after_rel_hdr: got pend=%0d, required 3", pending);
        end
    endtask

    task automatic test_mid_reset();
        exp_q.push_back({exp_addr(0, 1), 16'h8800});
        exp_q.push_back({exp_addr(0, 2), 16'h8801});
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 16'h8800;
        tick();
        in_sop = 1'b0; in_data = 16'h8801;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_wr = 0; m_rd = 0; m_pend = 0;
        tick();
        checks++;
        if (pending !== 3'd0 || drop_count !== 8'd0 || irq !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset: got pend=%0d drops=%0d irq=%b left=%0d, required 0 0 0 0",
                     pending, drop_count, irq, exp_q.size());
        end
        send_msg(3, 16'h9000, 1'b0);
        checks++;
        if (pending !== 3'd1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_next: got pend=%0d drops=%0d, required 1 0", pending, drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_rel_empty();
        test_basic();
        test_reset();
        test_single();
        test_trunc();
        test_full_drop();
        test_rel_at_hdr();
        test_reset();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
